// File: rtl/exe_stage.sv
// Execute stage: latches one decoded instruction, evaluates the one-hot ALU or runs the
// 32-step restoring divider, then hands off to MEM. Optional bypass outputs: `EXE_FWD_EN.
module exe_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_to_es_valid,
    output logic        es_allowin,
    input  logic [31:0] ds_pc,
    input  logic [11:0] ds_alu_op,
    input  logic [3:0]  ds_div_op,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic [4:0]  ds_dest,
    input  logic        ds_gr_we,
    input  logic        ms_allowin,
    output logic        es_to_ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_result,
    output logic [4:0]  es_dest,
    output logic        es_gr_we,
    output logic        es_div_busy
`ifdef EXE_FWD_EN
    ,
    output logic        es_fwd_valid,
    output logic        es_fwd_blk,
    output logic [4:0]  es_fwd_dest,
    output logic [31:0] es_fwd_data
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  state, state_nxt;
    logic        es_valid;
    logic        es_ready_go;
    logic [11:0] es_alu_op;
    logic [3:0]  es_div_op;
    logic [31:0] es_src1, es_src2;
    logic [4:0]  div_cnt;
    logic [31:0] div_r, div_q, div_d;

    // ---------------- handshake and input latch ----------------
    assign es_ready_go    = (es_div_op == '0) | (state == DONE);
    assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid & es_ready_go;
    assign es_div_busy    = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid  <= 1'b0;
            es_pc     <= '0;
            es_alu_op <= '0;
            es_div_op <= '0;
            es_src1   <= '0;
            es_src2   <= '0;
            es_dest   <= '0;
            es_gr_we  <= 1'b0;
        end else begin
            if (es_allowin)
                es_valid <= ds_to_es_valid;
            if (ds_to_es_valid && es_allowin) begin
                es_pc     <= ds_pc;
                es_alu_op <= ds_alu_op;
                es_div_op <= ds_div_op;
                es_src1   <= ds_src1;
                es_src2   <= ds_src2;
                es_dest   <= ds_dest;
                es_gr_we  <= ds_gr_we;
            end
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] add_res, sub_res, slt_res, sltu_res, sra_res, alu_result;

    assign add_res  = es_src1 + es_src2;
    assign sub_res  = es_src1 - es_src2;
    assign slt_res  = {31'b0, $signed(es_src1) < $signed(es_src2)};
    assign sltu_res = {31'b0, es_src1 < es_src2};
    assign sra_res  = 32'($signed(es_src1) >>> es_src2[4:0]);

    assign alu_result = ({32{es_alu_op[0]}}  & add_res)
                      | ({32{es_alu_op[1]}}  & sub_res)
                      | ({32{es_alu_op[2]}}  & slt_res)
                      | ({32{es_alu_op[3]}}  & sltu_res)
                      | ({32{es_alu_op[4]}}  & (es_src1 & es_src2))
                      | ({32{es_alu_op[5]}}  & ~(es_src1 | es_src2))
                      | ({32{es_alu_op[6]}}  & (es_src1 | es_src2))
                      | ({32{es_alu_op[7]}}  & (es_src1 ^ es_src2))
                      | ({32{es_alu_op[8]}}  & (es_src1 << es_src2[4:0]))
                      | ({32{es_alu_op[9]}}  & (es_src1 >> es_src2[4:0]))
                      | ({32{es_alu_op[10]}} & sra_res)
                      | ({32{es_alu_op[11]}} & es_src2);

    // ---------------- divider ----------------
    logic        div_signed, div_start, step_ge, q_neg, r_neg, div_by_zero;
    logic [31:0] abs1, abs2, step_sub, div_quot, div_rem;
    logic [32:0] step_t;

    assign div_signed = es_div_op[0] | es_div_op[1];
    assign div_start  = es_valid & (es_div_op != '0);
    assign abs1       = (div_signed & es_src1[31]) ? -es_src1 : es_src1;
    assign abs2       = (div_signed & es_src2[31]) ? -es_src2 : es_src2;

    // Partial remainder stays below the divisor, so the difference always fits 32 bits.
    assign step_t   = {div_r, div_q[31]};
    assign step_ge  = step_t >= {1'b0, div_d};
    assign step_sub = step_t[31:0] - div_d;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div_start) state_nxt = BUSY;
            BUSY:    if (div_cnt == 5'(DIV_CYCLES - 1)) state_nxt = DONE;
            DONE:    if (es_to_ms_valid && ms_allowin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            div_cnt <= '0;
            div_r   <= '0;
            div_q   <= '0;
            div_d   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (div_start) begin
                    div_r   <= '0;
                    div_q   <= abs1;
                    div_d   <= abs2;
                    div_cnt <= '0;
                end
                BUSY: begin
                    div_r   <= step_ge ? step_sub : step_t[31:0];
                    div_q   <= {div_q[30:0], step_ge};
                    div_cnt <= div_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Sign correction is applied on the held magnitudes while the FSM sits in DONE.
    assign div_by_zero = (es_src2 == '0);
    assign q_neg       = div_signed & (es_src1[31] ^ es_src2[31]);
    assign r_neg       = div_signed & es_src1[31];
    assign div_quot    = div_by_zero ? '1      : (q_neg ? -div_q : div_q);
    assign div_rem     = div_by_zero ? es_src1 : (r_neg ? -div_r : div_r);

    assign es_result = (es_div_op == '0)                ? alu_result :
                       (es_div_op[0] | es_div_op[2])    ? div_quot   : div_rem;

`ifdef EXE_FWD_EN
    assign es_fwd_valid = es_valid & es_gr_we & es_ready_go & (es_dest != '0);
    assign es_fwd_blk   = es_valid & es_gr_we & ~es_ready_go;
    assign es_fwd_dest  = es_dest;
    assign es_fwd_data  = es_result;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU/divider vector table plus
// hand-written back-to-back, MEM-stall and mid-division reset sequences.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [11:0] ds_alu_op;
    logic [3:0]  ds_div_op;
    logic [31:0] ds_src1, ds_src2;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc, es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_div_busy;
`ifdef EXE_FWD_EN
    logic        es_fwd_valid, es_fwd_blk;
    logic [4:0]  es_fwd_dest;
    logic [31:0] es_fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exe_stage #(.DIV_CYCLES(32)) dut (
        .clk(clk), .resetn(resetn),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_pc(ds_pc), .ds_alu_op(ds_alu_op), .ds_div_op(ds_div_op),
        .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
        .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_div_busy(es_div_busy)
`ifdef EXE_FWD_EN
        , .es_fwd_valid(es_fwd_valid), .es_fwd_blk(es_fwd_blk),
        .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data)
`endif
    );

    typedef struct {
        string       name;
        logic [11:0] alu_op;
        logic [3:0]  div_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] aop, input logic [3:0] dop,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] pc, input logic [4:0] dst, input logic we);
        ds_to_es_valid = v;
        ds_alu_op = aop;
        ds_div_op = dop;
        ds_src1   = s1;
        ds_src2   = s2;
        ds_pc     = pc;
        ds_dest   = dst;
        ds_gr_we  = we;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, stall;
        logic [31:0] pc;
        pc = 32'h1c00_0000 + 32'(idx * 4);
        ms_allowin = 1'b1;
        drive(1'b1, v.alu_op, v.div_op, v.src1, v.src2, pc, 5'(idx + 1), 1'b1);
        cyc();
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
        lat = 0;
        stall = 0;
        while (!es_to_ms_valid && lat < 40) begin
            if (!es_allowin) stall++;
            cyc();
            lat++;
        end
        check({v.name, "_latency"}, 32'(lat), (v.div_op != '0) ? 32'd33 : 32'd0);
        check({v.name, "_result"}, es_result, v.exp);
        if (v.div_op != '0)
            check({v.name, "_allowin_low"}, 32'(stall), 32'd33);
        check({v.name, "_pc"}, es_pc, pc);
        check({v.name, "_dest"}, {27'b0, es_dest}, 32'(idx + 1));
        cyc();
        check({v.name, "_drained"}, {30'b0, es_to_ms_valid, es_div_busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"add",      12'h001, 4'h0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002};
        vecs[1]  = '{"sub",      12'h002, 4'h0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[2]  = '{"slt",      12'h004, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3]  = '{"sltu",     12'h008, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[4]  = '{"and",      12'h010, 4'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
        vecs[5]  = '{"nor",      12'h020, 4'h0, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0};
        vecs[6]  = '{"xor",      12'h080, 4'h0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[7]  = '{"srl",      12'h200, 4'h0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        vecs[8]  = '{"sra",      12'h400, 4'h0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[9]  = '{"lui",      12'h800, 4'h0, 32'h0000_0000, 32'h1234_5000, 32'h1234_5000};
        vecs[10] = '{"nop_zero", 12'h000, 4'h0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};
        vecs[11] = '{"div_w",    12'h001, 4'h1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[12] = '{"mod_w",    12'h001, 4'h2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[13] = '{"div_wu",   12'h001, 4'h4, 32'd100,       32'd7,         32'd14};
        vecs[14] = '{"mod_wu",   12'h001, 4'h8, 32'd100,       32'd7,         32'd2};
        vecs[15] = '{"div_w_neg_divisor", 12'h001, 4'h1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[16] = '{"div_w_ovf",  12'h001, 4'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[17] = '{"mod_w_ovf",  12'h001, 4'h2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[18] = '{"mod_wu_z",   12'h001, 4'h8, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234};
        vecs[19] = '{"div_wu_z",   12'h001, 4'h4, 32'h0000_0037, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[20] = '{"mod_w_z",    12'h001, 4'h2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};

        resetn = 1'b0;
        ms_allowin = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
        #12;
        check("rst_allowin", {31'b0, es_allowin}, 32'd1);
        check("rst_valid",   {31'b0, es_to_ms_valid}, 32'd0);
        check("rst_busy",    {31'b0, es_div_busy}, 32'd0);
        check("rst_pc",      es_pc, 32'd0);
        check("rst_dest_we", {26'b0, es_dest, es_gr_we}, 32'd0);
        resetn = 1'b1;
        cyc();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: or, sll by 4, sltu with no bubbles.
        ms_allowin = 1'b1;
        check("b2b_allowin0", {31'b0, es_allowin}, 32'd1);
        drive(1'b1, 12'h040, 4'h0, 32'h0000_00F0, 32'h0000_0F00, 32'h100, 5'd1, 1'b1);
        cyc();
        check("b2b_or_valid",  {31'b0, es_to_ms_valid}, 32'd1);
        check("b2b_or_res",    es_result, 32'h0000_0FF0);
        check("b2b_allowin1",  {31'b0, es_allowin}, 32'd1);
        drive(1'b1, 12'h100, 4'h0, 32'h0000_0123, 32'h0000_0004, 32'h104, 5'd2, 1'b1);
        cyc();
        check("b2b_sll_valid", {31'b0, es_to_ms_valid}, 32'd1);
        check("b2b_sll_res",   es_result, 32'h0000_1230);
        check("b2b_sll_pc",    es_pc, 32'h104);
        check("b2b_allowin2",  {31'b0, es_allowin}, 32'd1);
        drive(1'b1, 12'h008, 4'h0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h108, 5'd3, 1'b1);
        cyc();
        check("b2b_sltu_valid", {31'b0, es_to_ms_valid}, 32'd1);
        check("b2b_sltu_res",   es_result, 32'h0000_0001);
        check("b2b_allowin3",   {31'b0, es_allowin}, 32'd1);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
        cyc();
        check("b2b_end_valid", {31'b0, es_to_ms_valid}, 32'd0);

        // MEM stall while the divider sits in DONE.
        begin
            int w = 0;
            ms_allowin = 1'b0;
            drive(1'b1, 12'h001, 4'h4, 32'd100, 32'd7, 32'h200, 5'd9, 1'b1);
            cyc();
            drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
            while (!es_to_ms_valid && w < 40) begin
                cyc();
                w++;
            end
            check("stall_latency", 32'(w), 32'd33);
            for (int k = 0; k < 5; k++) begin
                cyc();
                check("stall_valid",   {31'b0, es_to_ms_valid}, 32'd1);
                check("stall_result",  es_result, 32'd14);
                check("stall_busy",    {31'b0, es_div_busy}, 32'd1);
                check("stall_allowin", {31'b0, es_allowin}, 32'd0);
            end
            ms_allowin = 1'b1;
            #1;
            check("stall_release_allowin", {31'b0, es_allowin}, 32'd1);
            cyc();
            check("stall_drained", {30'b0, es_to_ms_valid, es_div_busy}, 32'd0);
        end

        // Asynchronous reset in BUSY cycle 10, then a plain add.
        ms_allowin = 1'b1;
        drive(1'b1, 12'h001, 4'h1, 32'hFFFF_FFF9, 32'h0000_0002, 32'h300, 5'd4, 1'b1);
        cyc();
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 10; k++) cyc();
        check("pre_rst_busy", {31'b0, es_div_busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy",    {31'b0, es_div_busy}, 32'd0);
        check("arst_valid",   {31'b0, es_to_ms_valid}, 32'd0);
        check("arst_allowin", {31'b0, es_allowin}, 32'd1);
        check("arst_pc",      es_pc, 32'd0);
        #2;
        resetn = 1'b1;
        cyc();
        run_vec(vecs[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
